stream_arbiter_flushable: RTL and testbench



---
 rtl/stream_arb_pkg.sv | 12 +
 rtl/stream_arbiter_flushable_rr_grant.sv | 31 +++
 rtl/stream_arbiter_flushable.sv | 133 +++++++++++++
 tb/tb_stream_arbiter_flushable.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types for stream_arbiter_flushable: the flush sequencer state encoding.
// The {payload, idx} entry struct is declared in the top, where the payload type T is known.
package stream_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    FLUSH = 2'd2,
    ACK   = 2'd3
  } flush_state_e;

endpackage

// File: rtl/stream_arbiter_flushable_rr_grant.sv
// Combinational round-robin grant: first asserted valid at or after ptr_i, wrapping.
// Produces a one-hot grant and its binary index; the pointer register is owned by the caller.
module rr_grant #(
  parameter int NumInp = 4,
  localparam int IdxW = $clog2(NumInp)
) (
  input  logic [NumInp-1:0] valid_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumInp-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic            found;
  logic [IdxW-1:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NumInp; i++) begin
      pos = IdxW'((int'(ptr_i) + i) % NumInp);
      if (!found && valid_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/stream_arbiter_flushable.sv
// Round-robin arbiter feeding a flushable two-entry (slice A + spill B) output buffer.
// Optional macro STREAM_ARB_FLUSH_STATS_EN adds the saturating dropped-beat counter.
//
// state | meaning
// IDLE  | arbitration and input handshakes enabled
// GATE  | inputs gated, output may still drain
// FLUSH | output masked, both entries cleared at end of cycle
// ACK   | flush_ack_o pulses, inputs still gated
module stream_arbiter_flushable
  import stream_arb_pkg::*;
#(
  parameter int  NumInp   = 4,
  parameter type T        = logic,
  parameter int  CntWidth = 8,
  localparam int IdxW     = $clog2(NumInp)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumInp-1:0]   inp_valid_i,
  output logic [NumInp-1:0]   inp_ready_o,
  input  T     [NumInp-1:0]   inp_data_i,
  output logic                oup_valid_o,
  input  logic                oup_ready_i,
  output T                    oup_data_o,
  output logic [IdxW-1:0]     oup_idx_o,
  input  logic                flush_req_i,
  output logic                flush_ack_o,
  output logic [CntWidth-1:0] drop_cnt_o
);

  typedef struct packed {
    T                payload;
    logic [IdxW-1:0] idx;
  } entry_t;

  flush_state_e    state_q, state_d;
  entry_t          a_q, b_q, in_entry;
  logic            a_full_q, b_full_q;
  logic            buf_ready, in_hs, out_ready_eff;
  logic            a_fill, a_drain, b_fill, b_drain;
  logic [NumInp-1:0] gnt;
  logic [IdxW-1:0] gnt_idx, ptr_q;

  rr_grant #(.NumInp(NumInp)) u_rr_grant (
    .valid_i (inp_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx)
  );

  // Ready looks only at registered fullness, so oup_ready_i never reaches inp_ready_o.
  assign buf_ready   = !a_full_q || !b_full_q;
  assign inp_ready_o = (state_q == IDLE && buf_ready) ? gnt : '0;
  assign in_hs       = |(inp_valid_i & inp_ready_o);
  assign in_entry    = {inp_data_i[gnt_idx], gnt_idx};

  assign oup_valid_o   = (a_full_q || b_full_q) && (state_q != FLUSH);
  assign out_ready_eff = oup_ready_i && (state_q != FLUSH);
  assign {oup_data_o, oup_idx_o} = b_full_q ? b_q : a_q;
  assign flush_ack_o   = (state_q == ACK);

  // A always empties when B is free: into the output if taken, else into B.
  assign a_fill  = in_hs;
  assign a_drain = a_full_q && !b_full_q;
  assign b_fill  = a_drain && !out_ready_eff;
  assign b_drain = b_full_q && out_ready_eff;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush_req_i) state_d = GATE;
      GATE:    state_d = FLUSH;
      FLUSH:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q      <= '0;
      b_q      <= '0;
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
    end else if (state_q == FLUSH) begin
      a_q      <= '0;
      b_q      <= '0;
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
    end else begin
      if (a_fill) a_q <= in_entry;
      if (b_fill) b_q <= a_q;
      a_full_q <= a_fill || (a_full_q && !a_drain);
      b_full_q <= b_fill || (b_full_q && !b_drain);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (in_hs) begin
      ptr_q <= (gnt_idx == IdxW'(NumInp - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

`ifdef STREAM_ARB_FLUSH_STATS_EN
  logic [CntWidth-1:0] drop_cnt_q;
  logic [CntWidth:0]   drop_sum;

  assign drop_sum = {1'b0, drop_cnt_q} + (CntWidth+1)'(a_full_q) + (CntWidth+1)'(b_full_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if (state_q == FLUSH) begin
      drop_cnt_q <= drop_sum[CntWidth] ? '1 : drop_sum[CntWidth-1:0];
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_arbiter_flushable.sv
// Bench for stream_arbiter_flushable: vector table, directed flush/reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_stream_arbiter_flushable;

  localparam int N  = 4;
  localparam int CW = 2;
`ifdef STREAM_ARB_FLUSH_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  typedef logic [7:0] data_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      valid, ready;
  data_t [N-1:0]     din;
  logic              ov, ordy;
  data_t             dout;
  logic [1:0]        oidx;
  logic              freq, fack;
  logic [CW-1:0]     dcnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_arbiter_flushable #(.NumInp(N), .T(data_t), .CntWidth(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .inp_valid_i (valid),
    .inp_ready_o (ready),
    .inp_data_i  (din),
    .oup_valid_o (ov),
    .oup_ready_i (ordy),
    .oup_data_o  (dout),
    .oup_idx_o   (oidx),
    .flush_req_i (freq),
    .flush_ack_o (fack),
    .drop_cnt_o  (dcnt)
  );

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] idx;
  } vec_t;

  typedef struct {
    data_t      d;
    logic [1:0] idx;
  } ent_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_drop(input int d);
    return Stats ? 32'(d) : 32'd0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    ordy  = 1'b0;
    freq  = 1'b0;
    #1;
    chk("rst_ov", 32'(ov), 0);
    chk("rst_ack", 32'(fack), 0);
    chk("rst_drop", 32'(dcnt), 0);
    chk("rst_data", 32'(dout), 0);
    chk("rst_idx", 32'(oidx), 0);
    chk("rst_ready", 32'(ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fill_and_flush(input int exp_d);
    ordy  = 1'b0;
    valid = 4'b0001;
    din[0] = 8'h70;
    settle();
    chk("sat_rdy0", 32'(ready), 32'h1);
    adv();
    din[0] = 8'h71;
    settle();
    chk("sat_rdy1", 32'(ready), 32'h1);
    adv();
    valid = '0;
    freq  = 1'b1;
    adv();
    freq = 1'b0;
    adv();
    adv();
    settle();
    chk("sat_ack", 32'(fack), 1);
    chk("sat_drop", 32'(dcnt), exp_drop(exp_d));
    adv();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int        ptr, phase, drops, g;
    logic [3:0] e_rdy;
    logic      e_ov;
    ent_t      q[$];

    tbl[0] = '{4'hF, 1'b1, 4'h1, 1'b0, 2'd0};
    tbl[1] = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd0};
    tbl[2] = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd1};
    tbl[3] = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd2};
    tbl[4] = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd3};
    tbl[5] = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd0};
    tbl[6] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd1};
    tbl[7] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0};

    for (int i = 0; i < N; i++) din[i] = data_t'(8'hB0 + i);
    valid = '0; ordy = 1'b0; freq = 1'b0;

    // Round-robin fairness
    do_reset();
    for (int i = 0; i < 8; i++) begin
      valid = tbl[i].valid;
      ordy  = tbl[i].ordy;
      settle();
      chk($sformatf("rr_rdy[%0d]", i), 32'(ready), 32'(tbl[i].rdy));
      chk($sformatf("rr_ov[%0d]", i), 32'(ov), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("rr_idx[%0d]", i), 32'(oidx), 32'(tbl[i].idx));
        chk($sformatf("rr_data[%0d]", i), 32'(dout), 32'h000000B0 + 32'(tbl[i].idx));
      end
      adv();
    end

    // Backpressure on a single requester
    do_reset();
    ordy = 1'b0; valid = 4'b0100; din[2] = 8'hA1;
    settle(); chk("bp_rdy0", 32'(ready), 32'h4); adv();
    din[2] = 8'hA2;
    settle(); chk("bp_rdy1", 32'(ready), 32'h4);
    chk("bp_data1", 32'(dout), 32'hA1); chk("bp_idx1", 32'(oidx), 2); adv();
    din[2] = 8'hA3;
    settle(); chk("bp_rdy2", 32'(ready), 32'h0); chk("bp_data2", 32'(dout), 32'hA1); adv();
    ordy = 1'b1;
    settle(); chk("bp_rdy3", 32'(ready), 32'h0); chk("bp_out3", 32'(dout), 32'hA1); adv();
    settle(); chk("bp_rdy4", 32'(ready), 32'h4); chk("bp_out4", 32'(dout), 32'hA2); adv();
    valid = '0;
    settle(); chk("bp_ov5", 32'(ov), 1); chk("bp_out5", 32'(dout), 32'hA3); adv();
    settle(); chk("bp_ov6", 32'(ov), 0); adv();

    // Flush with a full buffer
    do_reset();
    ordy = 1'b0; valid = 4'b0001; din[0] = 8'h11;
    settle(); chk("ff_rdy0", 32'(ready), 32'h1); adv();
    din[0] = 8'h12;
    settle(); chk("ff_rdy1", 32'(ready), 32'h1); adv();
    din[0] = 8'h13; freq = 1'b1;
    settle(); chk("ff_rdy2", 32'(ready), 32'h0); adv();
    freq = 1'b0;
    settle(); chk("ff_gate_rdy", 32'(ready), 0); chk("ff_gate_ov", 32'(ov), 1);
    chk("ff_gate_data", 32'(dout), 32'h11); chk("ff_gate_ack", 32'(fack), 0); adv();
    ordy = 1'b1;
    settle(); chk("ff_flush_rdy", 32'(ready), 0); chk("ff_flush_ov", 32'(ov), 0);
    chk("ff_flush_ack", 32'(fack), 0); adv();
    settle(); chk("ff_ack", 32'(fack), 1); chk("ff_ack_rdy", 32'(ready), 0);
    chk("ff_ack_ov", 32'(ov), 0); chk("ff_drop", 32'(dcnt), exp_drop(2)); adv();
    settle(); chk("ff_idle_ack", 32'(fack), 0); chk("ff_idle_rdy", 32'(ready), 32'h1); adv();
    valid = '0;
    settle(); chk("ff_lat_ov", 32'(ov), 1); chk("ff_lat_data", 32'(dout), 32'h13);
    chk("ff_lat_idx", 32'(oidx), 0); adv();

    // Empty flush, request held through ACK, then saturation
    do_reset();
    ordy = 1'b1; valid = '0; freq = 1'b1;
    settle(); chk("ef_ack0", 32'(fack), 0); adv();
    valid = 4'hF;
    settle(); chk("ef_gate_rdy", 32'(ready), 0); adv();
    settle(); chk("ef_flush_ov", 32'(ov), 0); adv();
    settle(); chk("ef_ack", 32'(fack), 1); chk("ef_drop", 32'(dcnt), 0); adv();
    valid = '0;
    settle(); chk("ef_idle_ack", 32'(fack), 0); adv();
    freq = 1'b0; valid = 4'hF;
    settle(); chk("ef2_gate_rdy", 32'(ready), 0); chk("ef2_gate_ack", 32'(fack), 0); adv();
    adv();
    valid = '0;
    settle(); chk("ef2_ack", 32'(fack), 1); chk("ef2_drop", 32'(dcnt), 0); adv();
    valid = 4'b0100; din[2] = 8'h5C;
    settle(); chk("ef_rdy", 32'(ready), 32'h4); adv();
    valid = '0;
    settle(); chk("ef_lat_ov", 32'(ov), 1); chk("ef_lat_data", 32'(dout), 32'h5C);
    chk("ef_lat_idx", 32'(oidx), 2); adv();
    fill_and_flush(2);
    fill_and_flush(3);
    fill_and_flush(3);

    // Async reset in FLUSH
    do_reset();
    ordy = 1'b0; valid = 4'b0010; din[1] = 8'h21;
    settle(); chk("ar_rdy0", 32'(ready), 32'h2); adv();
    settle(); chk("ar_rdy1", 32'(ready), 32'h2); adv();
    valid = '0; freq = 1'b1;
    adv();
    freq = 1'b0;
    adv();
    rst_n = 1'b0;
    #1;
    chk("ar_ov", 32'(ov), 0); chk("ar_ack", 32'(fack), 0); chk("ar_drop", 32'(dcnt), 0);
    chk("ar_data", 32'(dout), 0); chk("ar_idx", 32'(oidx), 0);
    adv();
    chk("ar_noack", 32'(fack), 0);
    rst_n = 1'b1; valid = 4'hF;
    settle(); chk("ar_ptr", 32'(ready), 32'h1); chk("ar_empty", 32'(ov), 0); adv();
    valid = '0;
    settle(); chk("ar_idx_after", 32'(oidx), 0); adv();

    // Randomized traffic against the queue model
    do_reset();
    ptr = 0; phase = 0; drops = 0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      valid = 4'($urandom);
      for (int i = 0; i < N; i++) din[i] = 8'($urandom);
      ordy = ($urandom_range(0, 9) < 7);
      freq = ($urandom_range(0, 24) == 0);
      g = -1;
      if (phase == 0 && q.size() < 2) begin
        for (int k = 0; k < N; k++) begin
          if (valid[(ptr + k) % N]) begin
            g = (ptr + k) % N;
            break;
          end
        end
      end
      e_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
      e_ov  = (q.size() > 0) && (phase != 2);
      settle();
      chk("rnd_rdy", 32'(ready), 32'(e_rdy));
      chk("rnd_ov", 32'(ov), 32'(e_ov));
      chk("rnd_ack", 32'(fack), 32'(phase == 3));
      chk("rnd_drop", 32'(dcnt), exp_drop(drops));
      if (e_ov) begin
        chk("rnd_data", 32'(dout), 32'(q[0].d));
        chk("rnd_idx", 32'(oidx), 32'(q[0].idx));
      end
      if (e_ov && ordy) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{din[g], 2'(g)});
        ptr = (g + 1) % N;
      end
      if (phase == 2) begin
        drops = drops + q.size();
        if (drops > 3) drops = 3;
        q.delete();
      end
      phase = (phase == 0) ? (freq ? 1 : 0) : (phase + 1) % 4;
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
